// File: rtl/rr_arbiter.sv
// Four-requester round-robin arbiter with a rotating priority pointer,
// a mandatory idle gap between grants and an optional hold-time limit.
module rr_arbiter #(
  parameter int HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld,
  output logic       timeout
);

  // Counter is at least 8 bits, wider only if HOLD_MAX needs it.
  localparam int CW = (HOLD_MAX > 255) ? $clog2(HOLD_MAX) + 1 : 8;
  localparam logic [CW-1:0] HOLD_LAST = CW'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [CW-1:0]   hold_q, hold_d;
  logic [1:0]      gnt_idx_q, gnt_idx_d;
  logic            gnt_vld_q, gnt_vld_d;
  logic            timeout_q, timeout_d;

  logic [1:0]      pick;
  logic [1:0]      cand;
  logic            found;
  logic            hold_limit;
  logic            req_lost;

  // Rotating scan starting at ptr; the first live request wins.
  always_comb begin
    pick  = ptr_q;
    cand  = ptr_q;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  assign hold_limit = (HOLD_MAX != 0) && (hold_q == HOLD_LAST);
  assign req_lost   = !req[gnt_idx_q];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gnt_idx_d = gnt_idx_q;
    gnt_vld_d = gnt_vld_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_vld_d = 1'b0;
        if (found) begin
          state_d   = GRANT;
          gnt_idx_d = pick;
          gnt_vld_d = 1'b1;
          hold_d    = '0;
        end
      end
      GRANT: begin
        if (done || req_lost || hold_limit) begin
          state_d   = IDLE;
          gnt_vld_d = 1'b0;
          ptr_d     = gnt_idx_q + 2'd1;
          // Timeout flags only releases the limit alone is responsible for.
          timeout_d = hold_limit && !done && !req_lost;
        end else begin
          hold_d = (hold_q == '1) ? hold_q : hold_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      hold_q    <= '0;
      gnt_idx_q <= 2'd0;
      gnt_vld_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_vld_q <= gnt_vld_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt_idx = gnt_idx_q;
  assign gnt_vld = gnt_vld_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter (HOLD_MAX=4): the driver queues the expected
// outputs after each edge, an independent monitor pops and compares them.
module tb_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  typedef struct {
    logic       vld;
    logic [1:0] idx;
    logic       to;
    string      name;
  } exp_t;

  exp_t expQ[$];
  int   testsRun;
  int   testsFailed;
  bit   driverDone;

  rr_arbiter #(.HOLD_MAX(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .done   (done),
    .gnt_idx(gnt_idx),
    .gnt_vld(gnt_vld),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue what the outputs must be after the edge.
  task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic d,
                               input logic ev, input logic [1:0] ei, input logic et,
                               input string nm);
    exp_t e;
    rst  = r;
    req  = rq;
    done = d;
    @(posedge clk);
    #1;
    e.vld  = ev;
    e.idx  = ei;
    e.to   = et;
    e.name = nm;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    testsRun++;
    if (gnt_vld !== e.vld || gnt_idx !== e.idx || timeout !== e.to) begin
      testsFailed++;
      $display("[TB] FAIL %s: got vld=%b idx=%0d to=%b, expected vld=%b idx=%0d to=%b",
               e.name, gnt_vld, gnt_idx, timeout, e.vld, e.idx, e.to);
    end
  endtask

  // Monitor samples mid-cycle, fully decoupled from the driver.
  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    driverDone  = 1'b0;
    rst = 1'b1; req = 4'b0000; done = 1'b0;

    applyStimulus(1, 4'b0000, 0, 0, 2'd0, 0, "reset");
    applyStimulus(1, 4'b1111, 1, 0, 2'd0, 0, "reset_priority");
    for (int i = 0; i < 5; i++)
      applyStimulus(0, 4'b0000, 0, 0, 2'd0, 0, "idle_no_req");

    applyStimulus(0, 4'b1010, 0, 1, 2'd1, 0, "first_grant_1");
    applyStimulus(0, 4'b1010, 1, 0, 2'd1, 0, "done_gap");
    applyStimulus(0, 4'b1010, 0, 1, 2'd3, 0, "grant_3");
    applyStimulus(0, 4'b1010, 1, 0, 2'd3, 0, "done_gap_3");

    applyStimulus(0, 4'b1111, 0, 1, 2'd0, 0, "rr_grant0");
    applyStimulus(0, 4'b1111, 1, 0, 2'd0, 0, "rr_gap0");
    applyStimulus(0, 4'b1111, 0, 1, 2'd1, 0, "rr_grant1");
    applyStimulus(0, 4'b1111, 1, 0, 2'd1, 0, "rr_gap1");
    applyStimulus(0, 4'b1111, 0, 1, 2'd2, 0, "rr_grant2");
    applyStimulus(0, 4'b1111, 1, 0, 2'd2, 0, "rr_gap2");
    applyStimulus(0, 4'b1111, 0, 1, 2'd3, 0, "rr_grant3");
    applyStimulus(0, 4'b1111, 1, 0, 2'd3, 0, "rr_gap3");
    applyStimulus(0, 4'b1111, 0, 1, 2'd0, 0, "rr_wrap0");
    applyStimulus(0, 4'b1111, 1, 0, 2'd0, 0, "rr_wrap_gap");

    applyStimulus(0, 4'b0001, 0, 1, 2'd0, 0, "hold_c1");
    applyStimulus(0, 4'b0001, 0, 1, 2'd0, 0, "hold_c2");
    applyStimulus(0, 4'b0001, 0, 1, 2'd0, 0, "hold_c3");
    applyStimulus(0, 4'b0001, 0, 1, 2'd0, 0, "hold_c4");
    applyStimulus(0, 4'b0001, 0, 0, 2'd0, 1, "timeout_pulse");
    applyStimulus(0, 4'b0001, 0, 1, 2'd0, 0, "regrant_0");
    applyStimulus(0, 4'b0000, 0, 0, 2'd0, 0, "req_drop_0");

    applyStimulus(0, 4'b0001, 0, 1, 2'd0, 0, "coinc_c1");
    applyStimulus(0, 4'b0001, 0, 1, 2'd0, 0, "coinc_c2");
    applyStimulus(0, 4'b0001, 0, 1, 2'd0, 0, "coinc_c3");
    applyStimulus(0, 4'b0001, 0, 1, 2'd0, 0, "coinc_c4");
    applyStimulus(0, 4'b0000, 1, 0, 2'd0, 0, "coinc_no_timeout");
    applyStimulus(0, 4'b0000, 0, 0, 2'd0, 0, "coinc_idle");

    applyStimulus(0, 4'b0100, 0, 1, 2'd2, 0, "grant_2");
    applyStimulus(0, 4'b0000, 0, 0, 2'd2, 0, "req2_drop");
    applyStimulus(0, 4'b1111, 0, 1, 2'd3, 0, "ptr_is_3");
    applyStimulus(1, 4'b1111, 0, 0, 2'd0, 0, "reset_mid_grant");
    applyStimulus(0, 4'b1111, 0, 1, 2'd0, 0, "post_reset_grant0");

    applyStimulus(0, 4'b0011, 0, 1, 2'd0, 0, "other_req_ignored");
    applyStimulus(0, 4'b1011, 1, 0, 2'd0, 0, "release_after_change");
    applyStimulus(0, 4'b0011, 0, 1, 2'd1, 0, "next_uses_new_req");
    applyStimulus(0, 4'b0011, 1, 0, 2'd1, 0, "final_release");

    driverDone = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!(driverDone && expQ.size() == 0) && budget < 2000) begin
      @(posedge clk);
      budget++;
    end
    if (budget >= 2000) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drain_timeout: %0d entries pending, required 0", expQ.size());
    end
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 The block SHALL have parameter HOLD_MAX, default 15, giving the maximum cycles one grant is held; 0 disables the limit.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port req  input  4  per-requester request, bit i = requester i.
REQ-005 The block SHALL have port done  input  1  the current grantee releases the grant this cycle.
REQ-006 The block SHALL have port gnt_idx  output  2  binary index of the granted requester, the 2-bit select feeding the 2-to-4 decoder.
REQ-007 The block SHALL have port gnt_vld  output  1  gnt_idx is a live grant.
REQ-008 The block SHALL have port timeout  output  1  one-cycle pulse marking a grant ended by HOLD_MAX.

Function
REQ-009 The block SHALL implement a two-state FSM, IDLE and GRANT, plus a 2-bit priority pointer ptr and a hold counter hold_cnt of at least 8 bits, all registered.
REQ-010 In IDLE with req != 0, the block SHALL select the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4), load it into gnt_idx, set gnt_vld=1, clear hold_cnt, and enter GRANT at the next edge (1-cycle latency).
REQ-011 In IDLE with req == 0, the block SHALL stay in IDLE with gnt_vld=0 and gnt_idx holding its last value.
REQ-012 In GRANT, the block SHALL release when done=1, when req[gnt_idx]=0, or when HOLD_MAX != 0 and hold_cnt == HOLD_MAX-1.
REQ-013 On release, the block SHALL enter IDLE at the next edge with gnt_vld=0 and ptr = gnt_idx+1 (mod 4, 3 wraps to 0).
REQ-014 Without release, the block SHALL stay in GRANT with gnt_idx unchanged and hold_cnt incremented by 1.
REQ-015 The block SHALL spend at least one IDLE cycle between grants, with no back-to-back grants and a gnt_vld low gap of exactly 1 cycle when requests are pending.
REQ-016 With HOLD_MAX=N>0, gnt_vld SHALL stay high at most N consecutive cycles.
REQ-017 timeout SHALL be 1 for exactly the first IDLE cycle after a release caused only by the hold limit (done=0 and req[gnt_idx]=1 in the releasing cycle); otherwise 0.
REQ-018 When done, a request drop and the hold limit coincide, the block SHALL release without asserting timeout.
REQ-019 Changes to req bits other than req[gnt_idx] during GRANT SHALL have no effect until the next IDLE cycle.
REQ-020 With HOLD_MAX=0, hold_cnt SHALL saturate at its maximum value and not wrap.

Reset
REQ-021 While rst=1 at a rising edge, the block SHALL set state=IDLE, ptr=0, hold_cnt=0, gnt_idx=0, gnt_vld=0 and timeout=0, taking priority over all other inputs.
REQ-022 A reset asserted during GRANT SHALL drop gnt_vld at that edge and SHALL NOT assert timeout.
REQ-023 After reset deasserts, the first arbitration SHALL start from ptr=0.

Verification
REQ-024 Reset then req=4'b0000 for 5 cycles -> gnt_vld=0, gnt_idx=0, timeout=0 throughout.
REQ-025 After reset, req=4'b1010 -> next cycle gnt_idx=1, gnt_vld=1; done pulse -> gnt_vld=0 for 1 cycle, then gnt_idx=3, gnt_vld=1.
REQ-026 req=4'b1111 held, done pulsed in every grant's first cycle -> grant order 0,1,2,3,0 with a 1-cycle gnt_vld gap each time.
REQ-027 HOLD_MAX=4, req=4'b0001 held, done=0 -> gnt_vld high exactly 4 cycles, then timeout=1 for 1 cycle with gnt_vld=0, then re-grant gnt_idx=0.
REQ-028 Grant to requester 2, then req[2] drops -> gnt_vld=0 next cycle, timeout=0, ptr=3.
REQ-029 rst pulsed mid-grant of requester 3 with req=4'b1111 -> gnt_vld=0, timeout=0 at the reset edge; the next grant is gnt_idx=0.
